// File: rtl/serial_rx_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_rx_deframer                                                         |
// | Hunts SOF 0x5A, captures N payload bits, checks EOF 0x0F, bursts words out. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module serial_rx_deframer #(
  parameter int data_width = 5,
  parameter int out_width  = 8
) (
  input  logic                 s_clk,
  input  logic                 rst_n,
  input  logic                 datain,
  input  logic                 dout_ready,
  output logic [out_width-1:0] dout,
  output logic                 dout_valid,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int N    = 1 << data_width;
  localparam int W    = N / out_width;
  localparam int IDXW = (W > 1) ? $clog2(W) : 1;
  localparam logic [7:0] c_SOF = 8'h5A;
  localparam logic [7:0] c_EOF = 8'h0F;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_DATA = 2'd1,
    S_EOF  = 2'd2
  } state_t;

  state_t                r_state;
  logic [6:0]            r_sr;
  logic [6:0]            r_eof;
  logic [data_width-1:0] r_cnt;
  logic [2:0]            r_dcnt;
  logic [N-1:0]          r_payload;
  logic [N-1:0]          r_obuf;
  logic [IDXW-1:0]       r_idx;
  logic                  r_valid;
  logic                  r_frame_err;
  logic                  r_overrun;

  logic [7:0] w_sr_next;
  logic [7:0] w_eof_next;
  logic       w_xfer;
  logic       w_last;
  logic       w_buf_free;
  logic       w_eof_done;
  logic       w_good;
  logic       w_load;

  always_comb begin
    w_sr_next  = {r_sr, datain};
    w_eof_next = {r_eof, datain};
    w_xfer     = r_valid && dout_ready;
    w_last     = w_xfer && (r_idx == IDXW'(W - 1));
    // Draining the final word on this edge frees the buffer for a new frame.
    w_buf_free = !r_valid || w_last;
    w_eof_done = (r_state == S_EOF) && (r_dcnt == 3'd7);
    w_good     = (w_eof_next == c_EOF);
    w_load     = w_eof_done && w_good && w_buf_free;
  end

  assign dout       = r_obuf[out_width-1:0];
  assign dout_valid = r_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HUNT;
      r_sr        <= '0;
      r_eof       <= '0;
      r_cnt       <= '0;
      r_dcnt      <= '0;
      r_payload   <= '0;
      r_obuf      <= '0;
      r_idx       <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      case (r_state)
        S_HUNT: begin
          r_sr <= w_sr_next[6:0];
          if (w_sr_next == c_SOF) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
          end
        end
        S_DATA: begin
          r_payload[r_cnt] <= datain;
          r_cnt            <= r_cnt + data_width'(1);
          if (r_cnt == data_width'(N - 1)) begin
            r_state <= S_EOF;
            r_dcnt  <= '0;
          end
        end
        S_EOF: begin
          r_eof  <= w_eof_next[6:0];
          r_dcnt <= r_dcnt + 3'd1;
          if (r_dcnt == 3'd7) begin
            // Clearing sr keeps EOF bits out of the next SOF search.
            r_state <= S_HUNT;
            r_sr    <= '0;
            if (!w_good)
              r_frame_err <= 1'b1;
            else if (!w_buf_free)
              r_overrun <= 1'b1;
          end
        end
        default: r_state <= S_HUNT;
      endcase

      if (w_load) begin
        r_obuf  <= r_payload;
        r_idx   <= '0;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_obuf <= r_obuf >> out_width;
        if (w_last) begin
          r_valid <= 1'b0;
          r_idx   <= '0;
        end else begin
          r_idx <= r_idx + IDXW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_rx_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serial_rx_deframer                                                      |
// | Scoreboard bench: stimulus queues expected words, negedge monitor checks.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_serial_rx_deframer;

  logic       s_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       datain = 1'b0;
  logic       dout_ready = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_err;
  logic       overrun;

  serial_rx_deframer #(.data_width(5), .out_width(8)) dut (
    .s_clk      (s_clk),
    .rst_n      (rst_n),
    .datain     (datain),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 s_clk = ~s_clk;

  int         errors = 0;
  int         checks = 0;
  int         fe_seen = 0;
  int         ov_seen = 0;
  logic [7:0] exp_q[$];
  logic       p_hold = 1'b0;
  logic [7:0] p_dout = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change at posedge+1, so values seen here are those the next edge samples.
  always @(negedge s_clk) begin
    if (rst_n) begin
      if (frame_err) fe_seen++;
      if (overrun)   ov_seen++;
      if (p_hold) chk("hold_stable", {23'd0, dout_valid, dout}, {23'd0, 1'b1, p_dout});
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", dout, $time);
        end else begin
          chk("word", {24'd0, dout}, {24'd0, exp_q.pop_front()});
        end
      end
      p_hold = dout_valid && !dout_ready;
      p_dout = dout;
    end else begin
      p_hold = 1'b0;
    end
  end

  task automatic bitout(input logic b);
    datain = b;
    @(posedge s_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bitout(1'b0);
  endtask

  task automatic send_sof();
    logic [7:0] s;
    s = 8'h5A;
    for (int i = 7; i >= 0; i--) bitout(s[i]);
  endtask

  task automatic send_payload(input logic [31:0] pl, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) bitout(pl[i]);
  endtask

  task automatic send_eof(input logic [7:0] e, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) bitout(e[i]);
  endtask

  task automatic push_words(input logic [31:0] pl);
    for (int k = 0; k < 4; k++) exp_q.push_back(pl[k*8 +: 8]);
  endtask

  task automatic send(input logic [31:0] pl, input logic [7:0] e, input bit push);
    if (push) push_words(pl);
    send_sof();
    send_payload(pl, 0, 31);
    send_eof(e, 7, 0);
  endtask

  initial begin
    logic [6:0] noise;
    noise = 7'b1101101;

    repeat (3) @(posedge s_clk);
    #1;
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Single good frame with continuous ready.
    dout_ready = 1'b1;
    send(32'hDEADBEEF, 8'h0F, 1'b1);
    chk("t1_ferr", {31'd0, frame_err}, 32'd0);
    chk("t1_ovr", {31'd0, overrun}, 32'd0);
    chk("t1_valid", {31'd0, dout_valid}, 32'd1);
    idle(4);
    chk("t1_drained", {31'd0, dout_valid}, 32'd0);

    // Bad EOF, then a good frame.
    send(32'hDEADBEEF, 8'h0E, 1'b0);
    chk("t2_ferr_pulse", {31'd0, frame_err}, 32'd1);
    chk("t2_no_valid", {31'd0, dout_valid}, 32'd0);
    idle(1);
    chk("t2_ferr_end", {31'd0, frame_err}, 32'd0);
    send(32'h12345678, 8'h0F, 1'b1);
    idle(6);

    // Line noise before SOF; payload made of 0x5A patterns.
    for (int i = 6; i >= 0; i--) bitout(noise[i]);
    send(32'h5A5A5A5A, 8'h0F, 1'b1);
    idle(6);

    // Backpressure: second back-to-back frame overruns.
    dout_ready = 1'b0;
    send(32'h0A0B0C0D, 8'h0F, 1'b1);
    send(32'hCAFEF00D, 8'h0F, 1'b0);
    chk("t4_ovr_pulse", {31'd0, overrun}, 32'd1);
    idle(1);
    chk("t4_ovr_end", {31'd0, overrun}, 32'd0);
    chk("t4_held", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'h0D});
    idle(5);
    dout_ready = 1'b1;
    idle(6);

    // Last word of frame 1 drains on frame 2's EOF edge.
    dout_ready = 1'b0;
    send(32'h11223344, 8'h0F, 1'b1);
    push_words(32'h55667788);
    send_sof();
    send_payload(32'h55667788, 0, 31);
    send_eof(8'h0F, 7, 4);
    dout_ready = 1'b1;
    send_eof(8'h0F, 3, 0);
    chk("t5_no_ovr", {31'd0, overrun}, 32'd0);
    chk("t5_new_w0", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'h88});
    idle(6);

    // Asynchronous reset mid-frame while a frame is held.
    dout_ready = 1'b0;
    send(32'h0BADF00D, 8'h0F, 1'b0);
    chk("t6_held_valid", {31'd0, dout_valid}, 32'd1);
    send_sof();
    send_payload(32'hFFFFFFFF, 0, 9);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dout", {24'd0, dout}, 32'd0);
    chk("t6_rst_valid", {31'd0, dout_valid}, 32'd0);
    send_payload(32'hFFFFFFFF, 10, 11);
    rst_n = 1'b1;
    send_payload(32'hFFFFFFFF, 12, 31);
    send_eof(8'h0F, 7, 0);
    chk("t6_abort_ignored", {31'd0, dout_valid}, 32'd0);
    dout_ready = 1'b1;
    idle(2);
    send(32'h89ABCDEF, 8'h0F, 1'b1);
    idle(8);

    chk("queue_empty", exp_q.size(), 32'd0);
    chk("ferr_total", fe_seen, 32'd1);
    chk("ovr_total", ov_seen, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_rx_deframer.md
# serial_rx_deframer

Receive end of the parallel-to-serial link: samples the one-bit serial line produced by the serial transmitter and hunts for the start delimiter 0x5A. It captures the fixed-length payload, checks the end delimiter 0x0F, and hands each good frame to the downstream parallel domain as a burst of words over a valid/ready interface. It sits in the `s_clk` domain at the far end of the serial wire and feeds the parallel side or a receive FIFO.

## Interface
- `data_width`, 5, log2 of payload bits per frame (N = 2**data_width = 32)
- `out_width`, 8, parallel word width; power of 2, must divide N; W = N/out_width words per frame
- `s_clk`  input  1  serial clock; all state on posedge
- `rst_n`  input  1  asynchronous, active-low reset
- `datain`  input  1  serial line; idle level 0; delimiters MSB first
- `dout_ready`  input  1  downstream accepts `dout` this cycle
- `dout`  output  out_width  current payload word
- `dout_valid`  output  1  `dout` holds a valid word
- `frame_err`  output  1  one-cycle pulse: end delimiter mismatch, frame discarded
- `overrun`  output  1  one-cycle pulse: good frame dropped because output buffer still busy

## Operation
- Frame on line: 8 SOF bits (0x5A, MSB first), N payload bits, 8 EOF bits (0x0F, MSB first). Total N+16 cycles, one bit per cycle.
- Payload bit order: the first payload bit received is payload[0]. Word k = payload[k*out_width +: out_width]. Words are emitted k = 0 to W-1.
- State HUNT:
  - Shift `sr <= {sr[6:0], datain}` every cycle.
  - If `{sr[6:0], datain} == 8'h5A`, go to DATA and clear the bit counter.
- State DATA:
  - Shift `datain` into the payload shift register at bit position `cnt`. `cnt` counts 0 to N-1.
  - At `cnt == N-1`, go to EOF and clear the delimiter counter.
  - No SOF detection occurs in DATA. A 0x5A pattern inside the payload is data.
- State EOF:
  - Shift 8 bits into the delimiter register.
  - On the 8th bit, compare `{eof[6:0], datain}` with 0x0F:
    - Match and output buffer free: copy payload to the output buffer; `dout_valid` goes to 1 with word 0.
    - Match and output buffer busy: pulse `overrun`; the payload is dropped.
    - Mismatch: pulse `frame_err`; the payload is dropped.
  - In all three cases, return to HUNT with `sr` cleared to 0. EOF bits therefore never contribute to SOF detection.
- Output buffer:
  - Holds one frame plus a word index.
  - A transfer occurs when `dout_valid && dout_ready` at an edge. On a transfer the index increments.
  - After the transfer of word W-1, `dout_valid` deasserts and the buffer becomes free.
  - `dout` is stable while `dout_valid && !dout_ready`.
- Simultaneous events: if the transfer of word W-1 happens on the same edge as a good EOF check, the buffer counts as free. The new frame loads, `dout_valid` stays 1, `dout` becomes word 0 of the new frame, and `overrun` stays 0.
- Reset, any time including mid-frame:
  - Outputs: `dout` = 0, `dout_valid` = 0, `frame_err` = 0, `overrun` = 0.
  - Internal: state HUNT, `sr` = 0, all counters = 0, output buffer empty.
  - A partial frame is lost.

## Timing
- Line sampled on every posedge of `s_clk`. No input synchronizer; `datain` is synchronous to `s_clk`.
- Latency: if the last EOF bit is sampled at edge E, then after E `frame_err`/`overrun` are high for exactly one cycle, or `dout_valid` is high.
- Drain time: W cycles with `dout_ready` held high. W ≤ N+16, so back-to-back frames with continuous ready never overrun.
- Gap between frames: any gap of zero or more idle bits is legal. SOF may start on the cycle after the last EOF bit.
- Bad-EOF or dropped frames never alter `dout`/`dout_valid` of the frame currently draining.

## Test plan
- Single frame, payload 0xDEADBEEF sent LSB first, `dout_ready` = 1 → after the EOF edge `dout` = 0xEF, 0xBE, 0xAD, 0xDE on 4 consecutive cycles, then `dout_valid` = 0; `frame_err` = `overrun` = 0.
- Same frame with EOF = 0x0E → exactly one `frame_err` pulse, `dout_valid` never rises. A following good frame with payload 0x12345678 → words 0x78, 0x56, 0x34, 0x12.
- Leading line noise 1,1,0,1,1,0,1 then a valid frame → SOF found by the sliding match; payload delivered correctly. A payload containing 0x5A bit patterns causes no resync.
- Backpressure: `dout_ready` = 0 from frame 1's EOF onward, frame 2 (0xCAFEF00D) sent back-to-back → `overrun` pulses once at frame 2's EOF. Frame 1 words are held stable, then delivered intact once `dout_ready` = 1; frame 2 is never output.
- Boundary: `dout_ready` timed so frame 1's word 3 transfers on frame 2's EOF edge → no `overrun`; `dout` = frame 2 word 0 the next cycle with `dout_valid` continuously 1.
- Assert `rst_n` = 0 for 2 cycles at payload bit 10 → all outputs 0 immediately. Remaining bits of the aborted frame are ignored. The next complete frame is delivered correctly.
